// File: rtl/icache_sa_param.sv
// Blocking set-associative read-only instruction cache with tree-PLRU replacement,
// single-beat line refill and a one-set-per-cycle invalidate sweep.
module icache_sa_param #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 256,
  parameter int LINE_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req_valid,
  input  logic [ADDR_W-1:0]            cpu_req_addr,
  output logic                         cpu_req_ready,
  output logic                         cpu_resp_valid,
  output logic [DATA_W-1:0]            cpu_resp_data,
  input  logic                         cpu_resp_ready,
  output logic                         mem_rd_req,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic                         mem_rd_addr_ok,
  input  logic                         mem_ret_valid,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_ret_data,
  input  logic                         inv_req,
  output logic                         inv_done,
  output logic                         miss_pulse
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_MISS_REQ  = 3'd2;
  localparam logic [2:0] S_MISS_WAIT = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;
  localparam logic [2:0] S_INV       = 3'd5;

  logic [2:0]        state_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [WORD_W-1:0] req_word_q;
  logic [IDX_W-1:0]  inv_idx_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [ADDR_W-1:0] mem_rd_addr_q;
  logic              inv_done_q;

  logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
  logic [PLRU_W-1:0]   plru_q  [NUM_SETS];

  logic [TAG_W-1:0]  tag_ram  [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0] data_ram [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0]  rd_tag   [NUM_WAYS];
  logic [LINE_W-1:0] rd_line  [NUM_WAYS];

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic [DATA_W-1:0] hit_word;
  logic [DATA_W-1:0] ret_word;
  logic              accept;
  logic [IDX_W-1:0]  in_idx;

  // Tree bits: b[0] picks the half holding the LRU way, b[1]/b[2] pick within each half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [2:0] b;
    logic [1:0] v;
    b = 3'(bits);
    v = 2'd0;
    if (NUM_WAYS == 4)      v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    else if (NUM_WAYS == 2) v = {1'b0, b[0]};
    return WAY_W'(v);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [2:0] b;
    logic [1:0] w;
    b = 3'(bits);
    w = 2'(way);
    if (NUM_WAYS == 4) begin
      if (!w[1]) begin b[0] = 1'b1; b[1] = ~w[0]; end
      else       begin b[0] = 1'b0; b[2] = ~w[0]; end
    end else if (NUM_WAYS == 2) begin
      b[0] = ~w[0];
    end
    return PLRU_W'(b);
  endfunction

  assign accept = (state_q == S_IDLE) && cpu_req_valid && !inv_req;
  assign in_idx = cpu_req_addr[OFF_W +: IDX_W];

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w][req_idx_q] && rd_tag[w] == req_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    victim = plru_victim(plru_q[req_idx_q]);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx_q]) victim = WAY_W'(w);
    end
  end

  assign hit_word = rd_line[hit_way][req_word_q*DATA_W +: DATA_W];
  assign ret_word = mem_ret_data[req_word_q*DATA_W +: DATA_W];

  // Ready is gated by rst_n so it stays low for the whole reset, not just after the first edge.
  assign cpu_req_ready  = rst_n && (state_q == S_IDLE) && !inv_req;
  assign mem_rd_req     = (state_q == S_MISS_REQ);
  assign miss_pulse     = (state_q == S_LOOKUP) && !hit;
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_data  = resp_data_q;
  assign mem_rd_addr    = mem_rd_addr_q;
  assign inv_done       = inv_done_q;

  // NOTE: tag/data arrays carry no reset; the valid flops make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        rd_tag[w]  <= tag_ram[w][in_idx];
        rd_line[w] <= data_ram[w][in_idx];
      end
    end
    if (state_q == S_MISS_WAIT && mem_ret_valid) begin
      tag_ram[victim][req_idx_q]  <= req_tag_q;
      data_ram[victim][req_idx_q] <= mem_ret_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_tag_q     <= '0;
      req_idx_q     <= '0;
      req_word_q    <= '0;
      inv_idx_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      mem_rd_addr_q <= '0;
      inv_done_q    <= 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else begin
      inv_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inv_req) begin
            inv_idx_q <= '0;
            state_q   <= S_INV;
          end else if (cpu_req_valid) begin
            req_tag_q  <= cpu_req_addr[ADDR_W-1 -: TAG_W];
            req_idx_q  <= in_idx;
            req_word_q <= cpu_req_addr[2 +: WORD_W];
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            resp_data_q       <= hit_word;
            resp_valid_q      <= 1'b1;
            plru_q[req_idx_q] <= plru_touch(plru_q[req_idx_q], hit_way);
            state_q           <= S_RESP;
          end else begin
            mem_rd_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            state_q       <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (mem_rd_addr_ok) state_q <= S_MISS_WAIT;
        end
        S_MISS_WAIT: begin
          if (mem_ret_valid) begin
            valid_q[victim][req_idx_q] <= 1'b1;
            plru_q[req_idx_q]          <= plru_touch(plru_q[req_idx_q], victim);
            resp_data_q                <= ret_word;
            resp_valid_q               <= 1'b1;
            state_q                    <= S_RESP;
          end
        end
        S_RESP: begin
          if (cpu_resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_INV: begin
          for (int w = 0; w < NUM_WAYS; w++) valid_q[w][inv_idx_q] <= 1'b0;
          plru_q[inv_idx_q] <= '0;
          if (inv_idx_q == IDX_W'(NUM_SETS - 1)) begin
            inv_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            inv_idx_q <= inv_idx_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_sa_param.sv
// Directed bench for icache_sa_param at default parameters: fills, hits, PLRU
// replacement, response back-pressure, invalidate sweep and reset during refill.
module tb_icache_sa_param;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req_valid;
  logic [31:0]  cpu_req_addr;
  logic         cpu_req_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         cpu_resp_ready;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_addr_ok;
  logic         mem_ret_valid;
  logic [255:0] mem_ret_data;
  logic         inv_req;
  logic         inv_done;
  logic         miss_pulse;

  int checks = 0;
  int errors = 0;

  icache_sa_param dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .cpu_resp_ready (cpu_resp_ready),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_addr_ok (mem_rd_addr_ok),
    .mem_ret_valid  (mem_ret_valid),
    .mem_ret_data   (mem_ret_data),
    .inv_req        (inv_req),
    .inv_done       (inv_done),
    .miss_pulse     (miss_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete fetch, called just after a falling edge. On a miss the line is
  // returned as words base+0 .. base+7. The response is held for 'hold' cycles.
  task automatic fetch(input string name, input logic [31:0] addr, input bit exp_miss,
                       input logic [31:0] base, input logic [31:0] exp_data, input int hold);
    check({name, "_req_ready"}, cpu_req_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    next_cycle();
    cpu_req_valid = 1'b0;
    check({name, "_miss_pulse"}, miss_pulse, exp_miss);
    check({name, "_early_valid"}, cpu_resp_valid, 0);
    if (exp_miss) begin
      next_cycle();
      check({name, "_mem_rd_req"}, mem_rd_req, 1);
      check({name, "_mem_rd_addr"}, mem_rd_addr, addr & 32'hFFFF_FFE0);
      mem_rd_addr_ok = 1'b1;
      next_cycle();
      mem_rd_addr_ok = 1'b0;
      check({name, "_wait_valid"}, cpu_resp_valid, 0);
      check({name, "_wait_req"}, mem_rd_req, 0);
      for (int i = 0; i < 8; i++) mem_ret_data[32*i +: 32] = base + 32'(i);
      mem_ret_valid = 1'b1;
      next_cycle();
      mem_ret_valid = 1'b0;
    end else begin
      next_cycle();
      check({name, "_hit_no_mem"}, mem_rd_req, 0);
    end
    for (int i = 0; i < hold; i++) begin
      check({name, "_resp_valid"}, cpu_resp_valid, 1);
      check({name, "_resp_data"}, cpu_resp_data, exp_data);
      check({name, "_busy"}, cpu_req_ready, 0);
      if (i < hold - 1) next_cycle();
    end
    cpu_resp_ready = 1'b1;
    next_cycle();
    cpu_resp_ready = 1'b0;
    check({name, "_resp_drop"}, cpu_resp_valid, 0);
    check({name, "_idle_ready"}, cpu_req_ready, 1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_req_ready"}, cpu_req_ready, 0);
    check({name, "_resp_valid"}, cpu_resp_valid, 0);
    check({name, "_resp_data"}, cpu_resp_data, 0);
    check({name, "_mem_rd_req"}, mem_rd_req, 0);
    check({name, "_mem_rd_addr"}, mem_rd_addr, 0);
    check({name, "_inv_done"}, inv_done, 0);
    check({name, "_miss_pulse"}, miss_pulse, 0);
  endtask

  initial begin
    int busy_cycles;

    rst_n          = 1'b0;
    cpu_req_valid  = 1'b0;
    cpu_req_addr   = '0;
    cpu_resp_ready = 1'b0;
    mem_rd_addr_ok = 1'b0;
    mem_ret_valid  = 1'b0;
    mem_ret_data   = '0;
    inv_req        = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    #1;
    check("reset_release_ready", cpu_req_ready, 1);
    @(negedge clk);

    // Cold miss, then hits in the same line; all lines map to set 0x80.
    fetch("cold_miss", 32'h0000_1004, 1'b1, 32'hA0, 32'hA1, 1);
    fetch("hit_100c",  32'h0000_100C, 1'b0, 32'h0,  32'hA3, 1);
    fetch("hit_1000",  32'h0000_1000, 1'b0, 32'h0,  32'hA0, 1);
    fetch("fill_3000", 32'h0000_3000, 1'b1, 32'hB0, 32'hB0, 1);
    fetch("rehit_1000", 32'h0000_1000, 1'b0, 32'h0, 32'hA0, 1);
    fetch("hit_3004",  32'h0000_3004, 1'b0, 32'h0,  32'hB1, 1);
    fetch("rehit2_1000", 32'h0000_1000, 1'b0, 32'h0, 32'hA0, 1);
    // Way1 (0x3000) is LRU, so 0x5000 replaces it.
    fetch("fill_5014", 32'h0000_5014, 1'b1, 32'hC0, 32'hC5, 1);
    fetch("keep_1000", 32'h0000_1000, 1'b0, 32'h0,  32'hA0, 1);
    fetch("evict_3008", 32'h0000_3008, 1'b1, 32'hB0, 32'hB2, 1);

    // Back-pressure: response held for three cycles before the CPU takes it.
    fetch("bp_101c", 32'h0000_101C, 1'b0, 32'h0, 32'hA7, 3);

    // Invalidate sweep.
    inv_req = 1'b1;
    #1;
    check("inv_blocks_ready", cpu_req_ready, 0);
    next_cycle();
    inv_req = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 300 && !inv_done; i++) begin
      if (!cpu_req_ready) busy_cycles++;
      next_cycle();
    end
    check("inv_busy_cycles", 32'(busy_cycles), 256);
    check("inv_done_pulse", inv_done, 1);
    next_cycle();
    check("inv_done_once", inv_done, 0);
    fetch("post_inv_miss", 32'h0000_1004, 1'b1, 32'hD0, 32'hD1, 1);

    // Reset while waiting for refill data.
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_2008;
    next_cycle();
    cpu_req_valid = 1'b0;
    check("rst_miss_pulse", miss_pulse, 1);
    next_cycle();
    check("rst_mem_rd_addr", mem_rd_addr, 32'h0000_2000);
    mem_rd_addr_ok = 1'b1;
    next_cycle();
    mem_rd_addr_ok = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_refill_reset");
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mem_ret_data[32*i +: 32] = 32'hF0 + 32'(i);
    mem_ret_valid = 1'b1;
    next_cycle();
    mem_ret_valid = 1'b0;
    check("late_ret_ignored", cpu_resp_valid, 0);
    check("late_ret_idle", cpu_req_ready, 1);
    fetch("post_rst_miss", 32'h0000_1004, 1'b1, 32'hE0, 32'hE1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
